// File: rtl/pulse_clkdiv_prog.sv
// rtl/pulse_clkdiv_prog.sv - programmable divider producing a divided clock and a tick strobe
//
// Ports:
//   clk      system clock, all registers update on its rising edge
//   rst      synchronous active-high reset
//   en       count enable; low freezes counter, state, clkout and div_cur
//   oneshot  0 = back-to-back periods, 1 = one period per start
//   start    launches a period from IDLE in one-shot mode
//   div_in   divisor to load
//   div_load strobe capturing div_in as the pending divisor
//   clkout   registered divided clock, high for ceil(N/2) cycles of each period
//   tick     one-cycle strobe on each clkout rising edge
//   busy     high while a period is running
//   div_cur  active divisor as loaded (before clamping)

module pulse_clkdiv_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             oneshot,
   input  logic             start,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             clkout,
   output logic             tick,
   output logic             busy,
   output logic [WIDTH-1:0] div_cur
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] pend;
   logic             pend_vld;

   logic [WIDTH-1:0] n;
   logic [WIDTH-1:0] h;
   logic [WIDTH-1:0] n_m1;
   logic [WIDTH-1:0] cnt_nx;
   logic             wrap;
   logic             launch;

   // Divisors 0 and 1 run as 2 so n-1 never underflows.
   assign n      = (div_cur < MIN_DIV) ? MIN_DIV : div_cur;
   // ceil(n/2) written without n+1 so n = 2**WIDTH-1 cannot overflow.
   assign h      = (n >> 1) + {{(WIDTH-1){1'b0}}, n[0]};
   assign n_m1   = n - 1'b1;
   assign cnt_nx = cnt + 1'b1;
   assign wrap   = (cnt == n_m1);

   assign launch = en && (((state == IDLE) && (!oneshot || start)) ||
                          ((state == RUN) && wrap && !oneshot));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         clkout   <= 1'b0;
         tick     <= 1'b0;
         busy     <= 1'b0;
         div_cur  <= DEF_DIV;
         pend     <= '0;
         pend_vld <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (launch) begin
            state  <= RUN;
            cnt    <= '0;
            clkout <= 1'b1;
            tick   <= 1'b1;
            busy   <= 1'b1;
            if (pend_vld) begin
               div_cur  <= pend;
               pend_vld <= 1'b0;
            end
         end else if (en) begin
            if (state == IDLE) begin
               clkout <= 1'b0;
            end else if (wrap) begin
               // one-shot wrap; continuous wraps are launches
               state  <= IDLE;
               cnt    <= '0;
               clkout <= 1'b0;
               busy   <= 1'b0;
            end else begin
               cnt    <= cnt_nx;
               clkout <= (cnt_nx < h);
            end
         end
         // Placed after the launch so a load on a launch edge survives as
         // pending for the following launch.
         if (div_load) begin
            pend     <= div_in;
            pend_vld <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pulse_clkdiv_prog.sv
// tb/tb_pulse_clkdiv_prog.sv - scoreboard bench for pulse_clkdiv_prog

module tb_pulse_clkdiv_prog;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       oneshot = 1'b0;
   logic       start = 1'b0;
   logic [7:0] div_in = 8'd0;
   logic       div_load = 1'b0;
   logic       clkout;
   logic       tick;
   logic       busy;
   logic [7:0] div_cur;

   int n_checks = 0;
   int n_fail   = 0;
   int stepno   = 0;
   logic os_mode = 1'b0;

   typedef struct {
      logic       chk;
      logic       c;
      logic       t;
      logic       b;
      logic [7:0] d;
      int         id;
   } exp_t;

   exp_t q[$];

   pulse_clkdiv_prog #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .oneshot  (oneshot),
      .start    (start),
      .div_in   (div_in),
      .div_load (div_load),
      .clkout   (clkout),
      .tick     (tick),
      .busy     (busy),
      .div_cur  (div_cur)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input int id, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0d expected %0d", name, id, got, exp);
      end
   endtask

   // Monitor: pops one expectation per clock, sampled 2 time units after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
               cmp("clkout",  e.id, {7'd0, clkout}, {7'd0, e.c});
               cmp("tick",    e.id, {7'd0, tick},   {7'd0, e.t});
               cmp("busy",    e.id, {7'd0, busy},   {7'd0, e.b});
               cmp("div_cur", e.id, div_cur,        e.d);
            end
         end
      end
   end

   task automatic step(input logic r, input logic e, input logic os, input logic st,
                       input logic dl, input logic [7:0] di, input logic ck,
                       input logic ec, input logic et, input logic eb, input logic [7:0] ed);
      @(negedge clk);
      rst      = r;
      en       = e;
      oneshot  = os;
      start    = st;
      div_load = dl;
      div_in   = di;
      stepno++;
      q.push_back('{chk: ck, c: ec, t: et, b: eb, d: ed, id: stepno});
   endtask

   task automatic cyc(input logic dl, input logic [7:0] di, input logic ec,
                      input logic et, input logic eb, input logic [7:0] ed);
      step(1'b0, 1'b1, os_mode, 1'b0, dl, di, 1'b1, ec, et, eb, ed);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      step(1, 0, 0, 0, 0, 8'd0, 1, 0, 0, 0, 8'd2);

      // continuous, default divide by 2
      os_mode = 1'b0;
      for (int i = 0; i < 6; i++)
         cyc(0, 8'd0, (i % 2) == 0, (i % 2) == 0, 1, 8'd2);

      // load 5 mid-period; takes effect on next launch
      cyc(0, 8'd0, 1, 1, 1, 8'd2);
      cyc(1, 8'd5, 0, 0, 1, 8'd2);
      for (int j = 0; j < 10; j++)
         cyc(0, 8'd0, (j % 5) < 3, (j % 5) == 0, 1, 8'd5);

      // load 4 on a launch edge: this period still uses 5
      cyc(1, 8'd4, 1, 1, 1, 8'd5);
      for (int j = 1; j < 5; j++)
         cyc(0, 8'd0, j < 3, 0, 1, 8'd5);

      // N=4 with a 3-cycle enable gap -> 7-cycle period
      cyc(0, 8'd0, 1, 1, 1, 8'd4);
      cyc(0, 8'd0, 1, 0, 1, 8'd4);
      cyc(0, 8'd0, 0, 0, 1, 8'd4);
      for (int g = 0; g < 3; g++)
         step(0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 1, 8'd4);
      cyc(0, 8'd0, 0, 0, 1, 8'd4);
      cyc(0, 8'd0, 1, 1, 1, 8'd4);

      // one-shot: finish current period, then one start-launched period
      os_mode = 1'b1;
      cyc(0, 8'd0, 1, 0, 1, 8'd4);
      cyc(0, 8'd0, 0, 0, 1, 8'd4);
      cyc(0, 8'd0, 0, 0, 1, 8'd4);
      cyc(0, 8'd0, 0, 0, 0, 8'd4);
      cyc(0, 8'd0, 0, 0, 0, 8'd4);
      step(0, 1, 1, 1, 0, 8'd0, 1, 1, 1, 1, 8'd4);
      step(0, 1, 1, 1, 0, 8'd0, 1, 1, 0, 1, 8'd4);
      cyc(0, 8'd0, 0, 0, 1, 8'd4);
      cyc(0, 8'd0, 0, 0, 1, 8'd4);
      cyc(0, 8'd0, 0, 0, 0, 8'd4);
      cyc(0, 8'd0, 0, 0, 0, 8'd4);

      // divisors 0 and 1 behave as 2
      cyc(1, 8'd0, 0, 0, 0, 8'd4);
      os_mode = 1'b0;
      cyc(0, 8'd0, 1, 1, 1, 8'd0);
      cyc(0, 8'd0, 0, 0, 1, 8'd0);
      cyc(0, 8'd0, 1, 1, 1, 8'd0);
      cyc(1, 8'd1, 0, 0, 1, 8'd0);
      cyc(0, 8'd0, 1, 1, 1, 8'd1);
      cyc(0, 8'd0, 0, 0, 1, 8'd1);
      cyc(0, 8'd0, 1, 1, 1, 8'd1);
      cyc(1, 8'd255, 0, 0, 1, 8'd1);

      // divide by 255: 128 high, 127 low; queue 6 as pending meanwhile
      cyc(0, 8'd0, 1, 1, 1, 8'd255);
      for (int k = 1; k < 255; k++)
         cyc(k == 1, 8'd6, k < 128, 0, 1, 8'd255);

      // N=6 high phase, pending 9, then reset discards it
      cyc(0, 8'd0, 1, 1, 1, 8'd6);
      cyc(1, 8'd9, 1, 0, 1, 8'd6);
      step(1, 1, 0, 0, 0, 8'd0, 1, 0, 0, 0, 8'd2);
      cyc(0, 8'd0, 1, 1, 1, 8'd2);
      cyc(0, 8'd0, 0, 0, 1, 8'd2);
      cyc(0, 8'd0, 1, 1, 1, 8'd2);

      @(posedge clk);
      #5;
      cmp("queue_drained", stepno, 8'(q.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
